// File: rtl/router_pkg.sv
// Shared types and defaults for the router buffer-memory arbiter.
package router_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } chan_t;

  // Increment modulo n, used to advance round-robin pointers past a winner.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  always_comb begin
    logic [PW-1:0] cand;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_mem_arbiter.sv
// Grants one router controller at a time a BURST_LEN-beat burst on the shared
// single-port buffer memory, with write preference bounded by MAX_WR_STREAK.
module router_mem_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int BURST_LEN     = 2,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            read_req,
  input  logic [NUM_REQ-1:0]            write_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] dst_addr,
  output logic [NUM_REQ-1:0]            read_gnt,
  output logic [NUM_REQ-1:0]            write_gnt,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          busy,
  output state_t                        state_dbg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SW = $clog2(MAX_WR_STREAK + 1);

  state_t                state;
  chan_t                 chan;
  logic [PW-1:0]         rd_ptr, wr_ptr, owner;
  logic [BW-1:0]         beat;
  logic [SW-1:0]         wr_streak;
  logic [ADDR_WIDTH-1:0] base;

  logic [NUM_REQ-1:0]    rd_onehot, wr_onehot;
  logic [PW-1:0]         rd_idx, wr_idx;
  logic                  rd_valid, wr_valid;
  logic                  pick_wr, owner_req, last_beat;
  logic [ADDR_WIDTH-1:0] rd_base, wr_base;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_rd_pick (
    .req(read_req), .ptr(rd_ptr), .gnt(rd_onehot), .idx(rd_idx), .valid(rd_valid)
  );

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_wr_pick (
    .req(write_req), .ptr(wr_ptr), .gnt(wr_onehot), .idx(wr_idx), .valid(wr_valid)
  );

  // Writes win unless a read has waited through MAX_WR_STREAK write bursts.
  assign pick_wr   = wr_valid && (!rd_valid || (wr_streak < SW'(MAX_WR_STREAK)));
  assign rd_base   = src_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_base   = dst_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign owner_req = (chan == WR) ? write_req[owner] : read_req[owner];
  assign last_beat = (beat == BW'(BURST_LEN - 1));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      chan      <= RD;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      owner     <= '0;
      beat      <= '0;
      wr_streak <= '0;
      base      <= '0;
      read_gnt  <= '0;
      write_gnt <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (pick_wr) begin
            state     <= BURST;
            chan      <= WR;
            owner     <= wr_idx;
            wr_ptr    <= PW'(wrap_inc(int'(wr_idx), NUM_REQ));
            base      <= wr_base;
            write_gnt <= wr_onehot;
            read_gnt  <= '0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wr_base;
            busy      <= 1'b1;
            // pick_wr with a read pending implies the streak is below the cap
            if (rd_valid) wr_streak <= wr_streak + SW'(1);
          end else if (rd_valid) begin
            state     <= BURST;
            chan      <= RD;
            owner     <= rd_idx;
            rd_ptr    <= PW'(wrap_inc(int'(rd_idx), NUM_REQ));
            base      <= rd_base;
            read_gnt  <= rd_onehot;
            write_gnt <= '0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= rd_base;
            busy      <= 1'b1;
            wr_streak <= '0;
          end
        end
        BURST: begin
          if (!owner_req || last_beat) begin
            state     <= GAP;
            read_gnt  <= '0;
            write_gnt <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
          end else begin
            beat     <= beat + BW'(1);
            mem_addr <= base + ADDR_WIDTH'(beat) + ADDR_WIDTH'(1);
          end
        end
        GAP: begin
          // Lets registered requesters drop a just-served request before IDLE looks again.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Scoreboarded bench for router_mem_arbiter: one instance with 2-beat bursts, one with 4.
module tb_router_mem_arbiter;
  import router_pkg::*;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int EW = 1 + 2*NR + AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    read_req, write_req, read_gnt, write_gnt;
  logic [NR*AW-1:0] src_addr, dst_addr;
  logic             mem_en, mem_we, busy;
  logic [AW-1:0]    mem_addr;
  state_t           st;

  logic [NR-1:0]    read_req4, write_req4, read_gnt4, write_gnt4;
  logic [NR*AW-1:0] src_addr4, dst_addr4;
  logic             mem_en4, mem_we4, busy4;
  logic [AW-1:0]    mem_addr4;
  state_t           st4;

  router_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .BURST_LEN(2), .MAX_WR_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n), .read_req(read_req), .write_req(write_req),
    .src_addr(src_addr), .dst_addr(dst_addr), .read_gnt(read_gnt), .write_gnt(write_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .busy(busy), .state_dbg(st)
  );

  router_mem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .BURST_LEN(4), .MAX_WR_STREAK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .read_req(read_req4), .write_req(write_req4),
    .src_addr(src_addr4), .dst_addr(dst_addr4), .read_gnt(read_gnt4), .write_gnt(write_gnt4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .busy(busy4), .state_dbg(st4)
  );

  int n_vec  = 0;
  int n_miss = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp4_q[$];

  function automatic logic [EW-1:0] beat_of(input logic we, input logic [NR-1:0] rg,
                                            input logic [NR-1:0] wg, input logic [AW-1:0] a);
    return {we, rg, wg, a};
  endfunction

  // Expected beats of one 2-beat burst on the main instance.
  task automatic push_burst(input logic we, input int who, input logic [AW-1:0] b);
    logic [NR-1:0] oh;
    oh = NR'(1) << who;
    for (int i = 0; i < 2; i++)
      exp_q.push_back(beat_of(we, we ? '0 : oh, we ? oh : '0, b + AW'(i)));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitors: every enabled memory cycle must match the next expected beat.
  always @(negedge clk) begin
    logic [EW-1:0] obs, e;
    if (rst_n) begin
      n_vec++;
      if ($countones(read_gnt | write_gnt | read_gnt4 | write_gnt4) > 2 ||
          $countones(read_gnt | write_gnt) > 1 || mem_en !== |(read_gnt | write_gnt) ||
          $countones(read_gnt4 | write_gnt4) > 1 || mem_en4 !== |(read_gnt4 | write_gnt4)) begin
        n_miss++;
        $display("FAIL grant_onehot got rg=%b wg=%b en=%b rg4=%b wg4=%b en4=%b want one-hot matching en",
                 read_gnt, write_gnt, mem_en, read_gnt4, write_gnt4, mem_en4);
      end
      if (mem_en) begin
        obs = {mem_we, read_gnt, write_gnt, mem_addr};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL beat_unexpected got we/rg/wg/addr=%h want no beat", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_miss++;
            $display("FAIL beat got we/rg/wg/addr=%h want %h", obs, e);
          end
        end
      end
      if (mem_en4) begin
        obs = {mem_we4, read_gnt4, write_gnt4, mem_addr4};
        n_vec++;
        if (exp4_q.size() == 0) begin
          n_miss++;
          $display("FAIL beat4_unexpected got we/rg/wg/addr=%h want no beat", obs);
        end else begin
          e = exp4_q.pop_front();
          if (obs !== e) begin
            n_miss++;
            $display("FAIL beat4 got we/rg/wg/addr=%h want %h", obs, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    read_req = '0; write_req = '0; read_req4 = '0; write_req4 = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Bounded wait for the main scoreboard to empty; a timeout is a miscompare.
  task automatic drain(input string name);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain got %0d beats outstanding want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    read_req = '1; write_req = '1; read_req4 = '1; write_req4 = '1;
    src_addr = '0; dst_addr = '0; src_addr4 = '0; dst_addr4 = '0;
    step();
    step();
    n_vec++;
    if ({read_gnt, write_gnt, mem_en, mem_we, mem_addr, busy, st} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs got rg=%b wg=%b en=%b we=%b addr=%h busy=%b st=%0d want all 0",
               read_gnt, write_gnt, mem_en, mem_we, mem_addr, busy, st);
    end
    n_vec++;
    if ({read_gnt4, write_gnt4, mem_en4, mem_we4, mem_addr4, busy4, st4} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs4 got rg=%b wg=%b en=%b busy=%b st=%0d want all 0",
               read_gnt4, write_gnt4, mem_en4, busy4, st4);
    end
    read_req = '0; write_req = '0; read_req4 = '0; write_req4 = '0;
    rst_n = 1'b1;
    step();
    n_vec++;
    if (st !== IDLE || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_no_req got st=%0d busy=%b want 0/0", st, busy);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    src_addr[1*AW +: AW] = 10'h040;
    read_req = 4'b0010;
    push_burst(1'b0, 1, 10'h040);
    step();
    n_vec++;
    if (read_gnt !== 4'b0010 || mem_we !== 1'b0 || busy !== 1'b1 || st !== BURST) begin
      n_miss++;
      $display("FAIL read_latency got rg=%b we=%b busy=%b st=%0d want 0010/0/1/%0d",
               read_gnt, mem_we, busy, st, BURST);
    end
    step();
    step();
    n_vec++;
    if (st !== GAP || read_gnt !== 4'b0000 || mem_en !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL read_gap got st=%0d rg=%b en=%b busy=%b want %0d/0000/0/1",
               st, read_gnt, mem_en, busy, GAP);
    end
    read_req = '0;
    step();
    n_vec++;
    if (st !== IDLE || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL read_idle got st=%0d busy=%b want %0d/0", st, busy, IDLE);
    end
    drain("single_read");
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NR; i++) src_addr[i*AW +: AW] = AW'(i * 'h100 + 'h10);
    foreach (order[k]) push_burst(1'b0, order[k], AW'(order[k] * 'h100 + 'h10));
    read_req = 4'b1111;
    drain("round_robin");
    read_req = '0;
    step(); step(); step();
    n_vec++;
    if (st !== IDLE || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL rr_settle got st=%0d busy=%b want %0d/0", st, busy, IDLE);
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    dst_addr[0*AW +: AW] = 10'h200;
    src_addr[2*AW +: AW] = 10'h080;
    for (int k = 0; k < 4; k++) push_burst(1'b1, 0, 10'h200);
    push_burst(1'b0, 2, 10'h080);
    push_burst(1'b1, 0, 10'h200);
    write_req = 4'b0001;
    read_req  = 4'b0100;
    drain("write_priority");
    write_req = '0;
    read_req  = '0;
    step(); step(); step();
    n_vec++;
    if (st !== IDLE) begin
      n_miss++;
      $display("FAIL wp_settle got st=%0d want %0d", st, IDLE);
    end
  endtask

  task automatic test_addr_wrap();
    do_reset();
    dst_addr[0*AW +: AW] = 10'h3FF;
    push_burst(1'b1, 0, 10'h3FF);
    write_req = 4'b0001;
    step();
    n_vec++;
    if (mem_addr !== 10'h3FF || mem_we !== 1'b1 || write_gnt !== 4'b0001) begin
      n_miss++;
      $display("FAIL wrap_beat0 got addr=%h we=%b wg=%b want 3ff/1/0001", mem_addr, mem_we, write_gnt);
    end
    step();
    n_vec++;
    if (mem_addr !== 10'h000) begin
      n_miss++;
      $display("FAIL wrap_beat1 got addr=%h want 000", mem_addr);
    end
    drain("addr_wrap");
    write_req = '0;
    step(); step(); step();
  endtask

  task automatic test_early_withdraw();
    do_reset();
    dst_addr4[3*AW +: AW] = 10'h123;
    exp4_q.push_back(beat_of(1'b1, 4'b0000, 4'b1000, 10'h123));
    write_req4 = 4'b1000;
    step();
    n_vec++;
    if (write_gnt4 !== 4'b1000 || mem_we4 !== 1'b1 || mem_addr4 !== 10'h123) begin
      n_miss++;
      $display("FAIL wd_beat0 got wg=%b we=%b addr=%h want 1000/1/123", write_gnt4, mem_we4, mem_addr4);
    end
    write_req4 = '0;
    step();
    n_vec++;
    if (write_gnt4 !== 4'b0000 || mem_en4 !== 1'b0 || st4 !== GAP || busy4 !== 1'b1) begin
      n_miss++;
      $display("FAIL wd_drop got wg=%b en=%b st=%0d busy=%b want 0000/0/%0d/1",
               write_gnt4, mem_en4, st4, busy4, GAP);
    end
    step();
    n_vec++;
    if (st4 !== IDLE) begin
      n_miss++;
      $display("FAIL wd_idle got st=%0d want %0d", st4, IDLE);
    end
    step(); step();
    n_vec++;
    if (exp4_q.size() != 0) begin
      n_miss++;
      $display("FAIL wd_drain got %0d beats outstanding want 0", exp4_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_addr[0*AW +: AW] = 10'h010;
    src_addr[1*AW +: AW] = 10'h050;
    push_burst(1'b0, 0, 10'h010);
    read_req = 4'b0001;
    drain("pre_reset");
    rst_n = 1'b0;
    step();
    n_vec++;
    if ({read_gnt, write_gnt, mem_en, busy, st} !== '0) begin
      n_miss++;
      $display("FAIL mid_reset got rg=%b wg=%b en=%b busy=%b st=%0d want all 0",
               read_gnt, write_gnt, mem_en, busy, st);
    end
    // Read pointer sat at 1 before reset; requester 0 winning proves it cleared.
    rst_n = 1'b1;
    read_req = 4'b0011;
    push_burst(1'b0, 0, 10'h010);
    step();
    n_vec++;
    if (read_gnt !== 4'b0001) begin
      n_miss++;
      $display("FAIL post_reset_grant got rg=%b want 0001", read_gnt);
    end
    drain("post_reset");
    read_req = '0;
    step(); step(); step();
  endtask

  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog got timeout want completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_addr_wrap();
    test_early_withdraw();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
